// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, taken-branch flush,
// multi-cycle multiply hold, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             ID_EX_MemRead_in,
  input  logic [4:0]       ID_EX_Rt_in,
  input  logic [4:0]       IF_ID_Rs_in,
  input  logic [4:0]       IF_ID_Rt_in,
  input  logic             IF_ID_Uses_Rt_in,
  input  logic             Branch_Taken_in,
  input  logic             Mul_Start_in,
  output logic             PC_Write_out,
  output logic             IF_ID_Write_out,
  output logic             IF_ID_Flush_out,
  output logic             ID_EX_Bubble_out,
  output logic             Mul_Busy_out,
  output logic [CNT_W-1:0] Stall_Count_out,
  output logic [1:0]       State_out
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_WAIT = 2'b01
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);
  localparam bit         MUL_EN   = (MUL_LATENCY > 1);

  state_t           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
                    ((ID_EX_Rt_in == IF_ID_Rs_in) ||
                     (IF_ID_Uses_Rt_in && (ID_EX_Rt_in == IF_ID_Rt_in)));

  always_comb begin
    state_d          = state_q;
    mul_cnt_d        = mul_cnt_q;
    stall_cnt_d      = stall_cnt_q;
    PC_Write_out     = 1'b0;
    IF_ID_Write_out  = 1'b0;
    IF_ID_Flush_out  = 1'b0;
    ID_EX_Bubble_out = 1'b1;
    Mul_Busy_out     = 1'b0;

    case (state_q)
      RUN: begin
        if (!load_use) begin
          PC_Write_out     = 1'b1;
          IF_ID_Write_out  = 1'b1;
          IF_ID_Flush_out  = Branch_Taken_in;
          ID_EX_Bubble_out = 1'b0;
          if (Mul_Start_in && MUL_EN) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_LOAD;
          end
        end
      end
      MUL_WAIT: begin
        Mul_Busy_out = 1'b1;
        mul_cnt_d    = mul_cnt_q - 1'b1;
        if (mul_cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset overrides the state-derived outputs: hold fetch, flush and bubble.
    if (reset_in) begin
      PC_Write_out     = 1'b0;
      IF_ID_Write_out  = 1'b0;
      IF_ID_Flush_out  = 1'b1;
      ID_EX_Bubble_out = 1'b1;
      Mul_Busy_out     = 1'b0;
    end

    if (!PC_Write_out && !reset_in && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= RUN;
      mul_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count_out = stall_cnt_q;
  assign State_out       = state_q;

endmodule
